fifo_param: RTL and testbench

Parametrised synchronous FIFO: the next-generation replacement for the fixed 5-bit × 4-entry FIFO used between stream stages. It adds configurable width and depth, an occupancy count, programmable almost-full/almost-empty flags, a synchronous flush, and sticky overflow/underflow error flags. When full, it accepts a write if a read happens in the same cycle. Read data is show-ahead: the head entry is presented combinationally whenever the FIFO is non-empty.

---
 rtl/fifo_param.sv | 96 +++++++++
 tb/tb_fifo_param.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/fifo_param.sv
// Parametrised show-ahead synchronous FIFO with occupancy count, almost flags,
// synchronous flush and sticky overflow/underflow error flags.
module fifo_param #(
    parameter int WIDTH    = 8,
    parameter int DEPTH    = 8,
    parameter int AF_LEVEL = 6,
    parameter int AE_LEVEL = 1,
    localparam int A       = $clog2(DEPTH)
) (
    input  logic             CLK,
    input  logic             RESETN,
    input  logic [WIDTH-1:0] wdata,
    input  logic             wen,
    output logic             full,
    output logic             almost_full,
    output logic [WIDTH-1:0] rdata,
    input  logic             ren,
    output logic             empty,
    output logic             almost_empty,
    output logic [A:0]       count,
    input  logic             flush,
    input  logic             clr_err,
    output logic             overflow,
    output logic             underflow
);

    localparam logic [A:0] PTR_ONE = (A+1)'(1);
    localparam logic [A:0] AF_LVL  = (A+1)'(AF_LEVEL);
    localparam logic [A:0] AE_LVL  = (A+1)'(AE_LEVEL);

    // Handshake: a write is taken on an edge where wen is high and either a
    // slot is free or a read pops the head in the same edge; a read is taken
    // on an edge where ren is high and the FIFO holds data. flush wins over both.

    logic [WIDTH-1:0] mem_q [DEPTH];

    logic [A:0] wptr_q, wptr_d;
    logic [A:0] rptr_q, rptr_d;
    logic       overflow_q, overflow_d;
    logic       underflow_q, underflow_d;

    logic       wvalid;
    logic       rvalid;
    logic       mem_we;

    // Status is decoded only from registered state.
    always_comb begin
        empty        = (wptr_q == rptr_q);
        full         = (wptr_q[A-1:0] == rptr_q[A-1:0]) && (wptr_q[A] != rptr_q[A]);
        count        = wptr_q - rptr_q;
        almost_full  = (count >= AF_LVL);
        almost_empty = (count <= AE_LVL);
        overflow     = overflow_q;
        underflow    = underflow_q;
        rdata        = mem_q[rptr_q[A-1:0]];
    end

    always_comb begin
        rvalid = ren && !empty;
        wvalid = wen && (!full || ren);
        mem_we = wvalid && !flush;

        wptr_d = wptr_q;
        rptr_d = rptr_q;
        if (flush) begin
            wptr_d = '0;
            rptr_d = '0;
        end else begin
            if (wvalid) wptr_d = wptr_q + PTR_ONE;
            if (rvalid) rptr_d = rptr_q + PTR_ONE;
        end

        // Set has priority over clr_err when both happen in one cycle.
        overflow_d  = (overflow_q && !clr_err)  || (wen && full && !ren && !flush);
        underflow_d = (underflow_q && !clr_err) || (ren && empty && !flush);
    end

    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            wptr_q      <= '0;
            rptr_q      <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    always_ff @(posedge CLK) begin
        if (mem_we) mem_q[wptr_q[A-1:0]] <= wdata;
    end

endmodule

// File: tb/tb_fifo_param.sv
// Directed bench for fifo_param at default parameters: fill, overflow,
// underflow, wrap-around streaming, flush priority and async reset.
module tb_fifo_param;

    logic       CLK = 1'b0;
    logic       RESETN;
    logic [7:0] wdata;
    logic       wen;
    logic       full;
    logic       almost_full;
    logic [7:0] rdata;
    logic       ren;
    logic       empty;
    logic       almost_empty;
    logic [3:0] count;
    logic       flush;
    logic       clr_err;
    logic       overflow;
    logic       underflow;

    int errors = 0;
    int checks = 0;

    fifo_param #(.WIDTH(8), .DEPTH(8), .AF_LEVEL(6), .AE_LEVEL(1)) dut (
        .CLK(CLK), .RESETN(RESETN), .wdata(wdata), .wen(wen), .full(full),
        .almost_full(almost_full), .rdata(rdata), .ren(ren), .empty(empty),
        .almost_empty(almost_empty), .count(count), .flush(flush),
        .clr_err(clr_err), .overflow(overflow), .underflow(underflow)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle();
        wen = 1'b0; ren = 1'b0; flush = 1'b0; clr_err = 1'b0; wdata = 8'h00;
    endtask

    logic [7:0] drain_exp [8];

    initial begin
        #100000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        idle();
        RESETN = 1'b0;
        #12;
        check("rst_empty", {31'd0, empty}, 32'd1);
        check("rst_full", {31'd0, full}, 32'd0);
        check("rst_count", {28'd0, count}, 32'd0);
        check("rst_ae", {31'd0, almost_empty}, 32'd1);
        check("rst_af", {31'd0, almost_full}, 32'd0);
        check("rst_ovf", {31'd0, overflow}, 32'd0);
        check("rst_unf", {31'd0, underflow}, 32'd0);
        RESETN = 1'b1;

        // 1: fill with 0x10..0x17
        for (int i = 0; i < 8; i++) begin
            wen = 1'b1; wdata = 8'h10 + 8'(i);
            tick();
            check("fill_count", {28'd0, count}, 32'(i + 1));
            check("fill_ae", {31'd0, almost_empty}, (i == 0) ? 32'd1 : 32'd0);
            check("fill_af", {31'd0, almost_full}, (i >= 5) ? 32'd1 : 32'd0);
            check("fill_full", {31'd0, full}, (i == 7) ? 32'd1 : 32'd0);
            check("fill_rdata", {24'd0, rdata}, 32'h10);
        end

        // 2: overflow drop, then full pass-through
        wen = 1'b1; wdata = 8'hAA; ren = 1'b0;
        tick();
        check("ovf_flag", {31'd0, overflow}, 32'd1);
        check("ovf_count", {28'd0, count}, 32'd8);
        check("ovf_rdata", {24'd0, rdata}, 32'h10);
        wen = 1'b1; wdata = 8'hBB; ren = 1'b1;
        tick();
        check("pass_count", {28'd0, count}, 32'd8);
        check("pass_full", {31'd0, full}, 32'd1);
        check("pass_rdata", {24'd0, rdata}, 32'h11);

        // 3: drain, underflow, clear
        drain_exp = '{8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16, 8'h17, 8'hBB};
        idle();
        ren = 1'b1;
        for (int i = 0; i < 8; i++) begin
            check("drain_rdata", {24'd0, rdata}, {24'd0, drain_exp[i]});
            tick();
        end
        check("drain_empty", {31'd0, empty}, 32'd1);
        check("drain_count", {28'd0, count}, 32'd0);
        check("drain_unf_clear", {31'd0, underflow}, 32'd0);
        tick();
        check("unf_count", {28'd0, count}, 32'd0);
        check("unf_flag", {31'd0, underflow}, 32'd1);
        check("unf_ovf_kept", {31'd0, overflow}, 32'd1);
        ren = 1'b0; clr_err = 1'b1;
        tick();
        check("clr_unf", {31'd0, underflow}, 32'd0);
        check("clr_ovf", {31'd0, overflow}, 32'd0);
        clr_err = 1'b0;

        // 4: prime with 0,1,2 then stream 40 cycles across pointer wrap
        for (int i = 0; i < 3; i++) begin
            wen = 1'b1; wdata = 8'(i);
            tick();
        end
        check("prime_count", {28'd0, count}, 32'd3);
        ren = 1'b1;
        for (int k = 0; k < 40; k++) begin
            wdata = 8'(k + 3);
            check("stream_rdata", {24'd0, rdata}, 32'(k));
            tick();
            check("stream_count", {28'd0, count}, 32'd3);
        end

        // 5: flush priority at count 5
        ren = 1'b0; wen = 1'b1;
        wdata = 8'd43; tick();
        wdata = 8'd44; tick();
        check("pre_flush_count", {28'd0, count}, 32'd5);
        flush = 1'b1; wen = 1'b1; ren = 1'b1; wdata = 8'hEE;
        tick();
        check("flush_count", {28'd0, count}, 32'd0);
        check("flush_empty", {31'd0, empty}, 32'd1);
        check("flush_ovf", {31'd0, overflow}, 32'd0);
        check("flush_unf", {31'd0, underflow}, 32'd0);
        wen = 1'b0; ren = 1'b1; flush = 1'b1;
        tick();
        check("flush_blocks_unf", {31'd0, underflow}, 32'd0);
        flush = 1'b0;
        tick();
        check("unf_after_flush", {31'd0, underflow}, 32'd1);
        ren = 1'b0; flush = 1'b1;
        tick();
        check("flush_keeps_unf", {31'd0, underflow}, 32'd1);
        flush = 1'b0; wen = 1'b1; wdata = 8'h5A;
        tick();
        check("post_flush_rdata", {24'd0, rdata}, 32'h5A);
        check("post_flush_count", {28'd0, count}, 32'd1);

        // 6: async reset between edges at count 4
        wdata = 8'h61; tick();
        wdata = 8'h62; tick();
        wdata = 8'h63; tick();
        wen = 1'b0;
        check("pre_rst_count", {28'd0, count}, 32'd4);
        #2 RESETN = 1'b0;
        #1;
        check("arst_empty", {31'd0, empty}, 32'd1);
        check("arst_count", {28'd0, count}, 32'd0);
        check("arst_unf", {31'd0, underflow}, 32'd0);
        check("arst_ovf", {31'd0, overflow}, 32'd0);
        check("arst_full", {31'd0, full}, 32'd0);
        #1 RESETN = 1'b1;
        wen = 1'b1; wdata = 8'h77;
        tick();
        check("post_rst_count", {28'd0, count}, 32'd1);
        check("post_rst_rdata", {24'd0, rdata}, 32'h77);
        idle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
